// File: rtl/keyed_state_lock.sv
// Key-gated present-state register for locked benchmark FSMs: a free-running
// window counter picks the expected key, and a mismatch loads that window's decoy state.
module keyed_state_lock #(
  parameter int                          NUM_KEYS    = 3,
  parameter int                          KEY_W       = 10,
  parameter int                          STATE_W     = 5,
  parameter int                          WINDOW_LEN  = 7,
  parameter logic [NUM_KEYS*KEY_W-1:0]   KEYS        = {10'd859, 10'd57, 10'd210},
  parameter logic [NUM_KEYS*STATE_W-1:0] DECOYS      = {5'd9, 5'd12, 5'd19},
  parameter logic [STATE_W-1:0]          RESET_STATE = STATE_W'(1),
  parameter bit                          STICKY      = 1'b0,
  localparam int                         IDX_W       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic [KEY_W-1:0]   key_in,
  input  logic [STATE_W-1:0] nx_state,
  output logic [STATE_W-1:0] pr_state,
  output logic [IDX_W-1:0]   win_idx
);

  localparam int CNT_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;

  localparam logic [CNT_W-1:0] SUB_LAST = CNT_W'(WINDOW_LEN - 1);
  localparam logic [IDX_W-1:0] WIN_LAST = IDX_W'(NUM_KEYS - 1);

  logic [CNT_W-1:0]   sub_cnt;
  logic               locked_out;
  logic [KEY_W-1:0]   key_sel;
  logic [STATE_W-1:0] decoy_sel;
  logic               match;

  // Key and decoy are chosen by the window index in force before the edge.
  always_comb begin
    key_sel   = KEYS[int'(win_idx)*KEY_W +: KEY_W];
    decoy_sel = DECOYS[int'(win_idx)*STATE_W +: STATE_W];
    match     = (key_in == key_sel);
  end

  // NOTE: every register here uses <= so all updates see the same pre-edge
  // win_idx/locked_out; blocking assignments would let the counter advance
  // before the key check reads it.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      pr_state   <= RESET_STATE;
      sub_cnt    <= '0;
      win_idx    <= '0;
      locked_out <= 1'b0;
    end else if (!hold) begin
      pr_state <= (match && !locked_out) ? nx_state : decoy_sel;

      if (STICKY && !match) locked_out <= 1'b1;

      if (sub_cnt == SUB_LAST) begin
        sub_cnt <= '0;
        win_idx <= (win_idx == WIN_LAST) ? '0 : win_idx + 1'b1;
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keyed_state_lock.sv
// Scoreboard bench for keyed_state_lock: default, sticky and single-window
// instances share stimulus; a monitor compares each falling-edge result.
module tb_keyed_state_lock;

  typedef struct {
    int         dut;
    logic [4:0] pr;
    logic [1:0] win;
    string      name;
  } exp_t;

  logic       clk = 1'b1;
  logic       rst = 1'b1;
  logic       hold = 1'b0;
  logic [9:0] key_in = '0;
  logic [4:0] nx_state = '0;

  logic [4:0] pr_a, pr_s, pr_m;
  logic [1:0] win_a, win_s;
  logic [0:0] win_m;

  exp_t sb[$];
  int   target = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  keyed_state_lock dut_a (
    .clk(clk), .rst(rst), .hold(hold), .key_in(key_in), .nx_state(nx_state),
    .pr_state(pr_a), .win_idx(win_a)
  );

  keyed_state_lock #(.STICKY(1'b1)) dut_s (
    .clk(clk), .rst(rst), .hold(hold), .key_in(key_in), .nx_state(nx_state),
    .pr_state(pr_s), .win_idx(win_s)
  );

  keyed_state_lock #(
    .NUM_KEYS(1), .WINDOW_LEN(1), .KEYS(10'd5), .DECOYS(5'd3)
  ) dut_m (
    .clk(clk), .rst(rst), .hold(hold), .key_in(key_in), .nx_state(nx_state),
    .pr_state(pr_m), .win_idx(win_m)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drive one falling edge's inputs and queue the result expected after it.
  task automatic step(input logic [9:0] k, input logic [4:0] nx, input logic h,
                      input logic [4:0] exp_pr, input logic [1:0] exp_win,
                      input string name);
    exp_t e;
    @(posedge clk);
    key_in   = k;
    nx_state = nx;
    hold     = h;
    e.dut  = target;
    e.pr   = exp_pr;
    e.win  = exp_win;
    e.name = name;
    sb.push_back(e);
  endtask

  // Pulse reset between falling edges and check the asynchronous clear.
  task automatic do_reset(input string name);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check({name, " pr_a"}, pr_a, 1);
    check({name, " win_a"}, win_a, 0);
    check({name, " pr_s"}, pr_s, 1);
    check({name, " pr_m"}, pr_m, 1);
    #1 rst = 1'b0;
    hold = 1'b0;
  endtask

  // Monitor: every falling edge produces a new result; compare it if one is owed.
  initial begin
    exp_t e;
    int pr, win;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.dut)
          1:       begin pr = pr_s; win = win_s; end
          2:       begin pr = pr_m; win = win_m; end
          default: begin pr = pr_a; win = win_a; end
        endcase
        check({e.name, " pr_state"}, pr, e.pr);
        check({e.name, " win_idx"}, win, e.win);
      end
    end
  end

  function automatic logic [9:0] good_key(input int e);
    case ((e / 7) % 3)
      0:       return 10'd210;
      1:       return 10'd57;
      default: return 10'd859;
    endcase
  endfunction

  function automatic logic [4:0] decoy(input int e);
    case ((e / 7) % 3)
      0:       return 5'd19;
      1:       return 5'd12;
      default: return 5'd9;
    endcase
  endfunction

  function automatic logic [1:0] win_after(input int e);
    return 2'((e + 1) / 7 % 3);
  endfunction

  initial begin
    // Correct key every window, then one edge past the wrap.
    target = 0;
    do_reset("rst0");
    for (int e = 0; e < 22; e++)
      step(good_key(e), 5'd7, 1'b0, 5'd7, win_after(e), $sformatf("good e%0d", e));

    // Key fixed at window 0's value: windows 1 and 2 load their decoys.
    do_reset("rst1");
    for (int e = 0; e < 21; e++) begin
      logic [4:0] nx;
      nx = 5'((e + 20) % 32);
      step(10'd210, nx, 1'b0, (e < 7) ? nx : decoy(e), win_after(e),
           $sformatf("fixed e%0d", e));
    end

    // Hold mid-window 1 with a wrong key; window 1 then finishes its 5 edges.
    do_reset("rst2");
    for (int e = 0; e < 9; e++)
      step(good_key(e), (e < 7) ? 5'd5 : 5'd6, 1'b0, (e < 7) ? 5'd5 : 5'd6,
           win_after(e), $sformatf("pre_hold e%0d", e));
    for (int i = 0; i < 5; i++)
      step(10'd0, 5'd30, 1'b1, 5'd6, 2'd1, $sformatf("hold i%0d", i));
    for (int i = 0; i < 5; i++)
      step(10'd57, 5'd11, 1'b0, 5'd11, (i == 4) ? 2'd2 : 2'd1,
           $sformatf("post_hold i%0d", i));
    step(10'd859, 5'd13, 1'b0, 5'd13, 2'd2, "win2 after hold");

    // Run to window 2 sub_cnt 4, then reset asynchronously between edges.
    do_reset("rst3");
    for (int e = 0; e < 18; e++)
      step(good_key(e), 5'd3, 1'b0, 5'd3, win_after(e), $sformatf("run e%0d", e));
    do_reset("rst_mid");
    step(10'd210, 5'd17, 1'b0, 5'd17, 2'd0, "after_rst key210");
    step(10'd57, 5'd18, 1'b0, 5'd19, 2'd0, "after_rst key57");

    // Sticky lockout: one wrong key on edge 3, decoys forever after.
    target = 1;
    do_reset("rst4");
    for (int e = 0; e < 28; e++) begin
      logic [4:0] nx;
      nx = 5'(e + 1);
      step((e == 3) ? 10'd0 : good_key(e), nx, 1'b0, (e < 3) ? nx : decoy(e),
           win_after(e), $sformatf("sticky e%0d", e));
    end

    // Single key, single-edge window.
    target = 2;
    do_reset("rst5");
    step(10'd5, 5'd2, 1'b0, 5'd2, 2'd0, "one key5 a");
    step(10'd5, 5'd4, 1'b0, 5'd4, 2'd0, "one key5 b");
    step(10'd6, 5'd8, 1'b0, 5'd3, 2'd0, "one key6 a");
    step(10'd6, 5'd10, 1'b0, 5'd3, 2'd0, "one key6 b");
    step(10'd5, 5'd31, 1'b0, 5'd31, 2'd0, "one key5 c");
    step(10'd5, 5'd0, 1'b0, 5'd0, 2'd0, "one key5 d");

    @(negedge clk);
    #3;
    check("scoreboard drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keyed_state_lock.md
# keyed_state_lock

Parametrised key-gated state register for the locked-FSM benchmark family. It replaces the hand-written window counter and key comparison found in each encrypted benchmark. A free-running window counter selects one of NUM_KEYS expected keys per time window. Each falling clock edge the block loads the host FSM's next state on a key match, or that window's decoy state on a mismatch. An optional sticky-lockout mode holds the block in decoy states permanently after the first mismatch.

## Interface
- NUM_KEYS, default 3: number of key windows, 1..16.
- KEY_W, default 10: key width in bits.
- STATE_W, default 5: state encoding width.
- WINDOW_LEN, default 7: falling edges per window, ≥1.
- KEYS, default {10'd859,10'd57,10'd210}: packed expected keys; window w uses KEYS[w*KEY_W +: KEY_W].
- DECOYS, default {5'd9,5'd12,5'd19}: packed decoy states; window w uses DECOYS[w*STATE_W +: STATE_W].
- RESET_STATE, default 1: pr_state value after reset.
- STICKY, default 0: 1 enables sticky lockout.

Ports:
- clk, input, 1: clock; all state changes on the falling edge.
- rst, input, 1: reset, asynchronous, active-high.
- hold, input, 1: when 1, counters, pr_state and the lockout flag freeze.
- key_in, input, KEY_W: applied key. key_in[KEY_W-1] is keyinput0.
- nx_state, input, STATE_W: combinational next state from the host FSM.
- pr_state, output, STATE_W: registered present state, fed back to the host FSM.
- win_idx, output, clog2(NUM_KEYS) (min 1): current window index, for observability.

## Operation
- Counters:
  - sub_cnt counts 0..WINDOW_LEN-1.
  - win_idx counts 0..NUM_KEYS-1.
  - On each un-held falling edge sub_cnt increments. At WINDOW_LEN-1 it wraps to 0 and win_idx increments.
  - win_idx wraps from NUM_KEYS-1 to 0.
  - Full period: NUM_KEYS*WINDOW_LEN edges.
- Key check: match = (key_in == KEYS[win_idx]), where win_idx is the pre-edge value.
- pr_state update on each un-held edge:
  - If match and not locked_out: pr_state ← nx_state.
  - Otherwise: pr_state ← DECOYS[win_idx] (pre-edge value).
- Sticky mode:
  - STICKY=1: an internal locked_out flag sets on the first edge with a mismatch. It clears only on rst.
  - STICKY=0: locked_out stays 0, and every window is judged independently.
- hold=1: all registers keep their values. No key check is made, so no lockout can be set.
- Window boundary: the update and the counter advance use the same edge. The last edge of window w is checked against key w. The next edge is checked against key w+1.
- nx_state values outside the legal encoding pass through unchanged; the host FSM's default branch handles them.
- Reset:
  - Asynchronous.
  - pr_state=RESET_STATE, sub_cnt=0, win_idx=0, locked_out=0.
  - A reset asserted mid-window restarts at window 0 on the first edge after release.

## Timing
- Latency: one falling edge from key_in/nx_state to pr_state. No combinational path from inputs to outputs.
- key_in and nx_state must be stable around the falling edge.
- With STICKY=1, the mismatch edge itself loads the decoy. All later edges load decoys, following win_idx.
- Reset release: the first falling edge with rst=0 evaluates window 0 at sub_cnt=0.
- NUM_KEYS=1 or WINDOW_LEN=1: counters still wrap correctly.
  - NUM_KEYS=1: win_idx is constant 0.
  - WINDOW_LEN=1: win_idx advances every edge.

## Test plan
- Defaults, correct key per window: 210 for edges 0–6, 57 for 7–13, 859 for 14–20, nx_state=5'd7 throughout → pr_state=7 after the first edge; win_idx sequence 0×7, 1×7, 2×7, then wraps to 0.
- Defaults, key fixed at 210 for 21 edges → pr_state=nx_state for edges 0–6, 12 for edges 7–13, 9 for edges 14–20.
- STICKY=1, wrong key (0) on edge 3 only, otherwise correct keys → edges 0–2 follow nx_state; edge 3 onward loads 19, then 12 in window 1, then 9 in window 2, repeating until rst.
- hold=1 for 5 edges mid-window 1 with a wrong key → pr_state and win_idx unchanged; window 1 then completes its remaining edges after hold drops.
- rst pulsed asynchronously between edges at sub_cnt=4 of window 2 → pr_state=1 and win_idx=0 immediately; the next edge is checked against key 210.
- NUM_KEYS=1, WINDOW_LEN=1, KEYS=10'd5, DECOYS=5'd3 → key 5 makes pr_state track nx_state every edge; key 6 gives pr_state=3; win_idx stays 0.
